// File: rtl/dep_issue_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sysbus_if                                                            |
// | Sysbus clock/reset bundle shared by the pipeline stages.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sysbus_if;
  logic clk;
  logic reset;

  modport slave (input clk, input reset);
endinterface
`default_nettype wire

// File: rtl/dep_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dep_issue_stage                                                      |
// | Two-entry decode issue buffer: builds register masks, obeys hazard   |
// | nops and releases instructions to operand fetch.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dep_issue_stage #(
  parameter int NREGS     = 16,
  parameter int IDW       = $clog2(NREGS),
  parameter int PAYLOAD_W = 64,
  parameter int CNT_W     = 8
) (
  sysbus_if.slave              bus,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 dec_src0_en,
  input  logic [IDW-1:0]       dec_src0,
  input  logic                 dec_src1_en,
  input  logic [IDW-1:0]       dec_src1,
  input  logic                 dec_dst_en,
  input  logic [IDW-1:0]       dec_dst,
  input  logic [NREGS-1:0]     dec_imp_req,
  input  logic [NREGS-1:0]     dec_imp_prov,
  output logic [NREGS-1:0]     id_out_req,
  output logic [NREGS-1:0]     id_out_prov,
  input  logic                 cl_out_nop_id,
  output logic                 of_valid,
  input  logic                 of_ready,
  output logic [PAYLOAD_W-1:0] of_payload,
  input  logic                 flush,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam logic [NREGS-1:0] c_one       = NREGS'(1);
  localparam logic [1:0]       c_depth     = 2'd2;
  localparam logic [CNT_W-1:0] c_stall_max = '1;

  logic [PAYLOAD_W-1:0] r_pay  [2];
  logic [NREGS-1:0]     r_req  [2];
  logic [NREGS-1:0]     r_prov [2];
  logic [1:0]           r_count;
  logic [CNT_W-1:0]     r_stall_cnt;

  logic             w_kill;
  logic             w_head_valid;
  logic             w_accept;
  logic             w_mask_en;
  logic             w_fire;
  logic             w_wr_idx;
  logic [NREGS-1:0] w_new_req;
  logic [NREGS-1:0] w_new_prov;

  assign w_kill       = flush | bus.reset;
  assign w_head_valid = (r_count != 2'd0);

  assign dec_ready = (r_count < c_depth) & ~w_kill;
  assign w_accept  = dec_valid & dec_ready;

  assign w_new_req  = (dec_src0_en ? (c_one << dec_src0) : '0)
                    | (dec_src1_en ? (c_one << dec_src1) : '0)
                    | dec_imp_req;
  assign w_new_prov = (dec_dst_en ? (c_one << dec_dst) : '0) | dec_imp_prov;

  // The hazard unit shifts its view every cycle, so masks only appear while OF is enabled.
  assign w_mask_en   = w_head_valid & of_ready & ~w_kill;
  assign id_out_req  = w_mask_en ? r_req[0]  : '0;
  assign id_out_prov = w_mask_en ? r_prov[0] : '0;

  assign of_valid   = w_mask_en & ~cl_out_nop_id;
  assign w_fire     = of_valid;
  assign of_payload = w_head_valid ? r_pay[0] : '0;
  assign stall_cnt  = r_stall_cnt;

  // A same-cycle pop shifts the skid entry down, so the new entry lands one slot lower.
  assign w_wr_idx = r_count[0] & ~w_fire;

  always_ff @(posedge bus.clk) begin
    if (bus.reset) begin
      r_count     <= 2'd0;
      r_stall_cnt <= '0;
      r_pay[0]    <= '0;
      r_pay[1]    <= '0;
      r_req[0]    <= '0;
      r_req[1]    <= '0;
      r_prov[0]   <= '0;
      r_prov[1]   <= '0;
    end else if (flush) begin
      r_count     <= 2'd0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fire) begin
        r_pay[0]  <= r_pay[1];
        r_req[0]  <= r_req[1];
        r_prov[0] <= r_prov[1];
      end
      if (w_accept) begin
        r_pay[w_wr_idx]  <= dec_payload;
        r_req[w_wr_idx]  <= w_new_req;
        r_prov[w_wr_idx] <= w_new_prov;
      end
      r_count <= r_count + 2'(w_accept) - 2'(w_fire);

      if (w_fire) begin
        r_stall_cnt <= '0;
      end else if (w_head_valid & of_ready & cl_out_nop_id & (r_stall_cnt != c_stall_max)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dep_issue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dep_issue_stage                                                   |
// | Directed self-checking bench for the decode issue buffer.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dep_issue_stage;
  localparam int NREGS = 16;
  localparam int IDW   = 4;
  localparam int PW    = 64;

  sysbus_if sbus ();

  logic             dec_valid, dec_ready, dec_src0_en, dec_src1_en, dec_dst_en;
  logic [PW-1:0]    dec_payload, of_payload;
  logic [IDW-1:0]   dec_src0, dec_src1, dec_dst;
  logic [NREGS-1:0] dec_imp_req, dec_imp_prov, id_out_req, id_out_prov;
  logic             cl_out_nop_id, of_valid, of_ready, flush;
  logic [7:0]       stall_cnt;

  // Narrow-counter instance shares all inputs, used for saturation checks.
  logic             dec_ready_s, of_valid_s;
  logic [NREGS-1:0] req_s, prov_s;
  logic [PW-1:0]    pay_s;
  logic [3:0]       stall_s;

  int n_checks = 0;
  int n_fails  = 0;

  dep_issue_stage #(.NREGS(NREGS), .IDW(IDW), .PAYLOAD_W(PW), .CNT_W(8)) dut (
    .bus(sbus), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_payload(dec_payload),
    .dec_src0_en(dec_src0_en), .dec_src0(dec_src0), .dec_src1_en(dec_src1_en), .dec_src1(dec_src1),
    .dec_dst_en(dec_dst_en), .dec_dst(dec_dst), .dec_imp_req(dec_imp_req), .dec_imp_prov(dec_imp_prov),
    .id_out_req(id_out_req), .id_out_prov(id_out_prov), .cl_out_nop_id(cl_out_nop_id),
    .of_valid(of_valid), .of_ready(of_ready), .of_payload(of_payload), .flush(flush),
    .stall_cnt(stall_cnt)
  );

  dep_issue_stage #(.NREGS(NREGS), .IDW(IDW), .PAYLOAD_W(PW), .CNT_W(4)) dut_s (
    .bus(sbus), .dec_valid(dec_valid), .dec_ready(dec_ready_s), .dec_payload(dec_payload),
    .dec_src0_en(dec_src0_en), .dec_src0(dec_src0), .dec_src1_en(dec_src1_en), .dec_src1(dec_src1),
    .dec_dst_en(dec_dst_en), .dec_dst(dec_dst), .dec_imp_req(dec_imp_req), .dec_imp_prov(dec_imp_prov),
    .id_out_req(req_s), .id_out_prov(prov_s), .cl_out_nop_id(cl_out_nop_id),
    .of_valid(of_valid_s), .of_ready(of_ready), .of_payload(pay_s), .flush(flush),
    .stall_cnt(stall_s)
  );

  initial sbus.clk = 1'b0;
  always #5 sbus.clk = ~sbus.clk;

  task automatic tick();
    @(posedge sbus.clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic dec(input logic v, input logic [PW-1:0] p,
                     input logic s0e, input logic [IDW-1:0] s0,
                     input logic s1e, input logic [IDW-1:0] s1,
                     input logic de, input logic [IDW-1:0] d);
    dec_valid    = v;
    dec_payload  = p;
    dec_src0_en  = s0e;
    dec_src0     = s0;
    dec_src1_en  = s1e;
    dec_src1     = s1;
    dec_dst_en   = de;
    dec_dst      = d;
    dec_imp_req  = '0;
    dec_imp_prov = '0;
  endtask

  task automatic test_reset();
    sbus.reset = 1'b1; flush = 1'b0; of_ready = 1'b1; cl_out_nop_id = 1'b0;
    dec(1'b1, 64'hDEAD, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 4'd2);
    tick(); tick(); settle();
    n_checks++; if (dec_ready !== 1'b0) begin n_fails++; $display("FAIL rst_ready_in_reset: got %b want 0", dec_ready); end
    n_checks++; if (dec_ready_s !== 1'b0) begin n_fails++; $display("FAIL rst_ready_s_in_reset: got %b want 0", dec_ready_s); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid_in_reset: got %b want 0", of_valid); end
    sbus.reset = 1'b0; dec_valid = 1'b0; settle();
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL rst_ready_after: got %b want 1", dec_ready); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL rst_valid_after: got %b want 0", of_valid); end
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL rst_req: got %h want 0000", id_out_req); end
    n_checks++; if (id_out_prov !== 16'h0) begin n_fails++; $display("FAIL rst_prov: got %h want 0000", id_out_prov); end
    n_checks++; if (of_payload !== 64'h0) begin n_fails++; $display("FAIL rst_payload: got %h want 0", of_payload); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL rst_not_accepted: got %b want 0", of_valid); end
  endtask

  task automatic test_issue();
    dec(1'b1, 64'h1111, 1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 4'd3); settle();
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL issue_ready: got %b want 1", dec_ready); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL issue_no_bypass: got %b want 0", of_valid); end
    tick(); dec_valid = 1'b0; settle();
    n_checks++; if (id_out_req !== 16'h0028) begin n_fails++; $display("FAIL issue_req: got %h want 0028", id_out_req); end
    n_checks++; if (id_out_prov !== 16'h0008) begin n_fails++; $display("FAIL issue_prov: got %h want 0008", id_out_prov); end
    n_checks++; if (of_valid !== 1'b1) begin n_fails++; $display("FAIL issue_valid: got %b want 1", of_valid); end
    n_checks++; if (of_payload !== 64'h1111) begin n_fails++; $display("FAIL issue_payload: got %h want 1111", of_payload); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL issue_empty_valid: got %b want 0", of_valid); end
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL issue_empty_req: got %h want 0000", id_out_req); end
    n_checks++; if (of_payload !== 64'h0) begin n_fails++; $display("FAIL issue_empty_payload: got %h want 0", of_payload); end
  endtask

  task automatic test_masks();
    dec(1'b1, 64'h2222, 1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 4'd9);
    dec_imp_req = 16'h8000; dec_imp_prov = 16'h4000; settle();
    tick(); dec_valid = 1'b0; dec_imp_req = '0; dec_imp_prov = '0; settle();
    n_checks++; if (id_out_req !== 16'h8001) begin n_fails++; $display("FAIL mask_req_imp: got %h want 8001", id_out_req); end
    n_checks++; if (id_out_prov !== 16'h4000) begin n_fails++; $display("FAIL mask_prov_imp: got %h want 4000", id_out_prov); end
    of_ready = 1'b0; settle();
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL mask_req_noready: got %h want 0000", id_out_req); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL mask_valid_noready: got %b want 0", of_valid); end
    n_checks++; if (of_payload !== 64'h2222) begin n_fails++; $display("FAIL mask_payload_noready: got %h want 2222", of_payload); end
    of_ready = 1'b1; settle();
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL mask_drained: got %b want 0", of_valid); end
  endtask

  task automatic test_hazard();
    dec(1'b1, 64'h3333, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 4'd2); settle();
    tick(); dec_valid = 1'b0; cl_out_nop_id = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL haz_valid[%0d]: got %b want 0", k, of_valid); end
      n_checks++; if (of_payload !== 64'h3333) begin n_fails++; $display("FAIL haz_payload[%0d]: got %h want 3333", k, of_payload); end
      n_checks++; if (stall_cnt !== 8'(k)) begin n_fails++; $display("FAIL haz_stall[%0d]: got %0d want %0d", k, stall_cnt, k); end
      n_checks++; if (req_s !== 16'h0002) begin n_fails++; $display("FAIL haz_req[%0d]: got %h want 0002", k, req_s); end
      tick();
    end
    settle();
    n_checks++; if (stall_cnt !== 8'd3) begin n_fails++; $display("FAIL haz_stall3: got %0d want 3", stall_cnt); end
    cl_out_nop_id = 1'b0; settle();
    n_checks++; if (of_valid !== 1'b1) begin n_fails++; $display("FAIL haz_release: got %b want 1", of_valid); end
    tick(); settle();
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL haz_stall_clear: got %0d want 0", stall_cnt); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL haz_empty: got %b want 0", of_valid); end
  endtask

  task automatic test_backpressure();
    of_ready = 1'b0;
    dec(1'b1, 64'hAAAA, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1, 4'd6); settle();
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL bp_ready0: got %b want 1", dec_ready); end
    tick();
    dec(1'b1, 64'hBBBB, 1'b0, 4'd0, 1'b1, 4'd9, 1'b1, 4'd10); cl_out_nop_id = 1'b1; settle();
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL bp_ready1: got %b want 1", dec_ready); end
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL bp_req_masked: got %h want 0000", id_out_req); end
    n_checks++; if (of_payload !== 64'hAAAA) begin n_fails++; $display("FAIL bp_head_payload: got %h want aaaa", of_payload); end
    tick();
    dec(1'b1, 64'hCCCC, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 4'd1); settle();
    n_checks++; if (dec_ready !== 1'b0) begin n_fails++; $display("FAIL bp_full: got %b want 0", dec_ready); end
    n_checks++; if (id_out_prov !== 16'h0) begin n_fails++; $display("FAIL bp_prov_masked: got %h want 0000", id_out_prov); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL bp_stall_hold: got %0d want 0", stall_cnt); end
    tick();
    dec_valid = 1'b0; cl_out_nop_id = 1'b0; of_ready = 1'b1; settle();
    n_checks++; if (of_valid !== 1'b1) begin n_fails++; $display("FAIL bp_a_valid: got %b want 1", of_valid); end
    n_checks++; if (of_payload !== 64'hAAAA) begin n_fails++; $display("FAIL bp_a_payload: got %h want aaaa", of_payload); end
    n_checks++; if (id_out_req !== 16'h0010) begin n_fails++; $display("FAIL bp_a_req: got %h want 0010", id_out_req); end
    n_checks++; if (prov_s !== 16'h0040) begin n_fails++; $display("FAIL bp_a_prov: got %h want 0040", prov_s); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b1) begin n_fails++; $display("FAIL bp_b_valid: got %b want 1", of_valid); end
    n_checks++; if (of_payload !== 64'hBBBB) begin n_fails++; $display("FAIL bp_b_payload: got %h want bbbb", of_payload); end
    n_checks++; if (id_out_req !== 16'h0200) begin n_fails++; $display("FAIL bp_b_req: got %h want 0200", id_out_req); end
    n_checks++; if (id_out_prov !== 16'h0400) begin n_fails++; $display("FAIL bp_b_prov: got %h want 0400", id_out_prov); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL bp_c_dropped: got %b want 0", of_valid); end
  endtask

  task automatic test_flush();
    of_ready = 1'b1; cl_out_nop_id = 1'b1;
    dec(1'b1, 64'hD0D0, 1'b1, 4'd2, 1'b0, 4'd0, 1'b0, 4'd0); settle(); tick();
    dec(1'b1, 64'hE0E0, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0); settle(); tick();
    dec_valid = 1'b0; settle();
    n_checks++; if (dec_ready !== 1'b0) begin n_fails++; $display("FAIL fl_full: got %b want 0", dec_ready); end
    n_checks++; if (stall_cnt !== 8'd1) begin n_fails++; $display("FAIL fl_stall1: got %0d want 1", stall_cnt); end
    tick();
    flush = 1'b1; cl_out_nop_id = 1'b0;
    dec(1'b1, 64'hF0F0, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL fl_valid: got %b want 0", of_valid); end
    n_checks++; if (dec_ready !== 1'b0) begin n_fails++; $display("FAIL fl_ready: got %b want 0", dec_ready); end
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL fl_req: got %h want 0000", id_out_req); end
    n_checks++; if (stall_cnt !== 8'd2) begin n_fails++; $display("FAIL fl_stall2: got %0d want 2", stall_cnt); end
    tick();
    flush = 1'b0; dec_valid = 1'b0; settle();
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL fl_stall_clear: got %0d want 0", stall_cnt); end
    n_checks++; if (of_payload !== 64'h0) begin n_fails++; $display("FAIL fl_payload: got %h want 0", of_payload); end
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL fl_ready_after: got %b want 1", dec_ready); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL fl_empty: got %b want 0", of_valid); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL fl_dropped: got %b want 0", of_valid); end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] exp_p;
    of_ready = 1'b1; cl_out_nop_id = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dec(1'b1, 64'h5000 + 64'(k), 1'b1, 4'(k), 1'b0, 4'd0, 1'b1, 4'(k + 8)); settle();
      n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, dec_ready); end
      if (k > 0) begin
        exp_p = 64'h5000 + 64'(k - 1);
        n_checks++; if (of_valid !== 1'b1) begin n_fails++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, of_valid); end
        n_checks++; if (of_payload !== exp_p) begin n_fails++; $display("FAIL b2b_payload[%0d]: got %h want %h", k, of_payload, exp_p); end
      end
      tick();
    end
    dec_valid = 1'b0; settle();
    n_checks++; if (of_payload !== 64'h5003) begin n_fails++; $display("FAIL b2b_last_payload: got %h want 5003", of_payload); end
    n_checks++; if (id_out_prov !== 16'h0800) begin n_fails++; $display("FAIL b2b_last_prov: got %h want 0800", id_out_prov); end
    tick(); settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL b2b_empty: got %b want 0", of_valid); end
  endtask

  task automatic test_saturation();
    dec(1'b1, 64'h7777, 1'b1, 4'd6, 1'b0, 4'd0, 1'b1, 4'd7); settle();
    tick(); dec_valid = 1'b0; cl_out_nop_id = 1'b1;
    repeat (20) tick();
    settle();
    n_checks++; if (stall_cnt !== 8'd20) begin n_fails++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
    n_checks++; if (stall_s !== 4'd15) begin n_fails++; $display("FAIL sat_narrow: got %0d want 15", stall_s); end
    n_checks++; if (pay_s !== 64'h7777) begin n_fails++; $display("FAIL sat_payload: got %h want 7777", pay_s); end
    cl_out_nop_id = 1'b0; settle();
    n_checks++; if (of_valid_s !== 1'b1) begin n_fails++; $display("FAIL sat_release: got %b want 1", of_valid_s); end
    tick(); settle();
    n_checks++; if (stall_s !== 4'd0) begin n_fails++; $display("FAIL sat_narrow_clear: got %0d want 0", stall_s); end
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL sat_wide_clear: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    dec(1'b1, 64'h8888, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0); settle();
    tick(); dec_valid = 1'b0; cl_out_nop_id = 1'b1;
    tick(); tick(); settle();
    n_checks++; if (stall_cnt !== 8'd2) begin n_fails++; $display("FAIL rms_stall2: got %0d want 2", stall_cnt); end
    sbus.reset = 1'b1; dec_valid = 1'b1; cl_out_nop_id = 1'b0; settle();
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL rms_valid: got %b want 0", of_valid); end
    n_checks++; if (id_out_req !== 16'h0) begin n_fails++; $display("FAIL rms_req: got %h want 0000", id_out_req); end
    n_checks++; if (dec_ready !== 1'b0) begin n_fails++; $display("FAIL rms_ready: got %b want 0", dec_ready); end
    tick();
    sbus.reset = 1'b0; dec_valid = 1'b0; settle();
    n_checks++; if (stall_cnt !== 8'd0) begin n_fails++; $display("FAIL rms_stall_clear: got %0d want 0", stall_cnt); end
    n_checks++; if (of_valid !== 1'b0) begin n_fails++; $display("FAIL rms_empty: got %b want 0", of_valid); end
    n_checks++; if (of_payload !== 64'h0) begin n_fails++; $display("FAIL rms_payload: got %h want 0", of_payload); end
    n_checks++; if (dec_ready !== 1'b1) begin n_fails++; $display("FAIL rms_ready_after: got %b want 1", dec_ready); end
  endtask

  initial begin
    test_reset();
    test_issue();
    test_masks();
    test_hazard();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
